// File: rtl/module_status_streamer_pkg.sv
// Shared definitions for the module status streamer: state codes, ASCII
// constants, the state field width and the FSM state type.
package module_status_streamer_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_ARMD = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd2;
  localparam logic [STATE_W-1:0] ST_FAIL = 2'd3;

  localparam logic [7:0] ASCII_COLON   = 8'h3A;
  localparam logic [7:0] ASCII_SPACE   = 8'h20;
  localparam logic [7:0] ASCII_NEWLINE = 8'h0A;

  // char_idx positions within one 7-byte module field; 7 marks the trailing newline
  localparam logic [2:0] CHAR_HEX_IDX     = 3'd0;
  localparam logic [2:0] CHAR_COLON_IDX   = 3'd1;
  localparam logic [2:0] CHAR_SPACE_IDX   = 3'd6;
  localparam logic [2:0] CHAR_NEWLINE_IDX = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_DONE
  } stream_state_e;

  function automatic logic [7:0] hex_digit(input logic [3:0] v);
    return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
  endfunction

endpackage

// File: rtl/module_status_streamer_status_word_rom.sv
// Four-letter status word lookup: (state code, letter index) -> ASCII byte.
module status_word_rom
  import module_status_streamer_pkg::*;
(
  input  logic [STATE_W-1:0] state_code,
  input  logic [1:0]         letter_idx,
  output logic [7:0]         ascii
);

  logic [31:0] word;

  always_comb begin
    case (state_code)
      ST_IDLE: word = "IDLE";
      ST_ARMD: word = "ARMD";
      ST_DONE: word = "DONE";
      default: word = "FAIL";
    endcase
    // letter 0 is the most significant byte of the packed string
    ascii = word[{~letter_idx, 3'b000} +: 8];
  end

endmodule

// File: rtl/module_status_streamer.sv
// Snapshots NUM_MODULES packed module states and streams them as one ASCII
// status line over a valid/ready byte interface.
//
//   state  | meaning
//   S_IDLE | waiting for send, a pending request or (AUTO_SEND) a state change
//   S_EMIT | presenting frame bytes, one per accepted transfer
//   S_DONE | one-cycle frame_done pulse before returning to S_IDLE
module module_status_streamer
  import module_status_streamer_pkg::*;
#(
  parameter int NUM_MODULES = 4,
  parameter bit AUTO_SEND   = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [STATE_W*NUM_MODULES-1:0] states_in,
  input  logic                           send,
  output logic [7:0]                     char_out,
  output logic                           char_valid,
  input  logic                           char_ready,
  output logic                           char_last,
  output logic                           busy,
  output logic                           frame_done
);

  localparam int         SW       = STATE_W * NUM_MODULES;
  localparam logic [3:0] LAST_MOD = 4'(NUM_MODULES - 1);

  stream_state_e state;
  logic [SW-1:0] shadow;
  logic [SW-1:0] last_sent;
  logic          pend_req;
  logic [3:0]    module_idx;
  logic [2:0]    char_idx;

  logic          start;
  logic          xfer;
  logic [3:0]    nxt_module;
  logic [2:0]    nxt_char;
  logic [SW-1:0] src_states;
  logic [1:0]    rom_code;
  logic [1:0]    rom_letter;
  logic [7:0]    rom_ascii;
  logic [7:0]    nxt_byte;

  assign start = (state == S_IDLE) &&
                 (send || pend_req || (AUTO_SEND && (states_in != last_sent)));
  assign xfer  = char_valid && char_ready;

  // Position of the byte to be loaded at the next advance; in S_IDLE that is
  // the first byte, taken from the live inputs that are about to be snapshotted.
  always_comb begin
    nxt_module = module_idx;
    nxt_char   = char_idx + 3'd1;
    src_states = shadow;
    if (state == S_IDLE) begin
      nxt_module = '0;
      nxt_char   = CHAR_HEX_IDX;
      src_states = states_in;
    end else if (char_idx == CHAR_SPACE_IDX) begin
      if (module_idx == LAST_MOD) begin
        nxt_char = CHAR_NEWLINE_IDX;
      end else begin
        nxt_module = module_idx + 4'd1;
        nxt_char   = CHAR_HEX_IDX;
      end
    end
  end

  always_comb begin
    rom_code = '0;
    for (int i = 0; i < NUM_MODULES; i++) begin
      if (nxt_module == 4'(i)) rom_code = src_states[STATE_W*i +: STATE_W];
    end
  end

  assign rom_letter = 2'(nxt_char - 3'd2);

  status_word_rom u_word_rom (
    .state_code (rom_code),
    .letter_idx (rom_letter),
    .ascii      (rom_ascii)
  );

  always_comb begin
    case (nxt_char)
      CHAR_HEX_IDX:     nxt_byte = hex_digit(nxt_module);
      CHAR_COLON_IDX:   nxt_byte = ASCII_COLON;
      CHAR_SPACE_IDX:   nxt_byte = ASCII_SPACE;
      CHAR_NEWLINE_IDX: nxt_byte = ASCII_NEWLINE;
      default:          nxt_byte = rom_ascii;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      shadow     <= '0;
      last_sent  <= '0;
      pend_req   <= 1'b0;
      module_idx <= '0;
      char_idx   <= '0;
      char_out   <= 8'h00;
      char_valid <= 1'b0;
      char_last  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            shadow     <= states_in;
            last_sent  <= states_in;
            pend_req   <= 1'b0;
            module_idx <= nxt_module;
            char_idx   <= nxt_char;
            char_out   <= nxt_byte;
            char_valid <= 1'b1;
            char_last  <= 1'b0;
            busy       <= 1'b1;
            state      <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (send) pend_req <= 1'b1;
          if (xfer) begin
            if (char_last) begin
              char_valid <= 1'b0;
              char_last  <= 1'b0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              state      <= S_DONE;
            end else begin
              module_idx <= nxt_module;
              char_idx   <= nxt_char;
              char_out   <= nxt_byte;
              char_last  <= (nxt_char == CHAR_NEWLINE_IDX);
            end
          end
        end
        S_DONE: begin
          if (send) pend_req <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_module_status_streamer.sv
// Bench for module_status_streamer: three configurations checked every cycle
// against a frame-text model, plus directed literal expectations.
module tb_module_status_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut0: 4 modules, AUTO_SEND=0; dut1: 4 modules, AUTO_SEND=1; dut2: 16 modules, AUTO_SEND=0
  logic        rst [3];
  logic        send[3];
  logic        rdy [3];
  logic [7:0]  s0, s1;
  logic [31:0] s2;
  logic [7:0]  co[3];
  logic        cv[3], cl[3], bz[3], fd[3];

  module_status_streamer #(.NUM_MODULES(4), .AUTO_SEND(1'b0)) dut0 (
    .clk(clk), .reset(rst[0]), .states_in(s0), .send(send[0]),
    .char_out(co[0]), .char_valid(cv[0]), .char_ready(rdy[0]),
    .char_last(cl[0]), .busy(bz[0]), .frame_done(fd[0]));

  module_status_streamer #(.NUM_MODULES(4), .AUTO_SEND(1'b1)) dut1 (
    .clk(clk), .reset(rst[1]), .states_in(s1), .send(send[1]),
    .char_out(co[1]), .char_valid(cv[1]), .char_ready(rdy[1]),
    .char_last(cl[1]), .busy(bz[1]), .frame_done(fd[1]));

  module_status_streamer #(.NUM_MODULES(16), .AUTO_SEND(1'b0)) dut2 (
    .clk(clk), .reset(rst[2]), .states_in(s2), .send(send[2]),
    .char_out(co[2]), .char_valid(cv[2]), .char_ready(rdy[2]),
    .char_last(cl[2]), .busy(bz[2]), .frame_done(fd[2]));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // model state per DUT
  logic [31:0] exq[3][8];
  int          qh[3], qt[3];
  logic [31:0] cur_snap[3];
  int          pos[3], ncap[3], frames[3];
  int          first_cyc[3], lastx_cyc[3], fd_cyc[3], gap[3], busy_cnt[3];
  bit          infr[3], prev_stall[3], prev_lastx[3], rst_d[3];
  logic [7:0]  prev_co[3];
  logic        prev_cl[3];
  logic [7:0]  cap[3][128];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int nmods(input int k);
    return (k == 2) ? 16 : 4;
  endfunction

  // Expected byte p of a frame describing snapshot snap with n modules.
  function automatic logic [7:0] frame_byte(input int n, input logic [31:0] snap, input int p);
    string hex = "0123456789ABCDEF";
    string wd;
    int m, c;
    logic [31:0] code;
    if (p == 7 * n) return 8'h0A;
    if (p > 7 * n) return 8'h00;
    m = p / 7;
    c = p % 7;
    code = (snap >> (2 * m)) & 32'd3;
    case (code)
      0: wd = "IDLE";
      1: wd = "ARMD";
      2: wd = "DONE";
      default: wd = "FAIL";
    endcase
    case (c)
      0: return hex.getc(m);
      1: return 8'h3A;
      6: return 8'h20;
      default: return wd.getc(c - 2);
    endcase
  endfunction

  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (rst_d[k]) begin
        chk("rst_char_valid", cv[k], 0);
        chk("rst_char_out", co[k], 0);
        chk("rst_char_last", cl[k], 0);
        chk("rst_busy", bz[k], 0);
        chk("rst_frame_done", fd[k], 0);
        infr[k]       = 0;
        qh[k]         = qt[k];
        prev_stall[k] = 0;
        prev_lastx[k] = 0;
      end else begin
        chk("frame_done", fd[k], prev_lastx[k]);
        if (fd[k]) fd_cyc[k] = cyc;
        chk("busy_vs_valid", bz[k], cv[k]);
        if (prev_stall[k]) begin
          chk("stall_valid", cv[k], 1);
          chk("stall_char_out", co[k], prev_co[k]);
          chk("stall_char_last", cl[k], prev_cl[k]);
        end
        if (cv[k] && !infr[k]) begin
          infr[k]      = 1;
          pos[k]       = 0;
          ncap[k]      = 0;
          busy_cnt[k]  = 0;
          first_cyc[k] = cyc;
          gap[k]       = cyc - fd_cyc[k];
          if (qh[k] == qt[k]) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame dut%0d: frame started at cycle %0d, none required", k, cyc);
            cur_snap[k] = '0;
          end else begin
            cur_snap[k] = exq[k][qh[k] % 8];
            qh[k]++;
          end
        end
        if (bz[k]) busy_cnt[k]++;
        prev_lastx[k] = 0;
        if (cv[k] && rdy[k] && infr[k]) begin
          chk("char_out", co[k], frame_byte(nmods(k), cur_snap[k], pos[k]));
          chk("char_last", cl[k], pos[k] == 7 * nmods(k));
          if (ncap[k] < 128) cap[k][ncap[k]] = co[k];
          ncap[k]++;
          pos[k]++;
          if (cl[k]) begin
            infr[k]       = 0;
            frames[k]++;
            lastx_cyc[k]  = cyc;
            prev_lastx[k] = 1;
          end
        end
        prev_stall[k] = cv[k] && !rdy[k];
        prev_co[k]    = co[k];
        prev_cl[k]    = cl[k];
      end
      rst_d[k] = rst[k];
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic [31:0] v);
    exq[k][qt[k] % 8] = v;
    qt[k]++;
  endtask

  task automatic pulse_send(input int k);
    send[k] = 1'b1;
    tick(1);
    send[k] = 1'b0;
  endtask

  task automatic wait_frames(input int k, input int target, input int budget);
    int t = 0;
    while (frames[k] < target && t < budget) begin
      tick(1);
      t++;
    end
    checks++;
    if (frames[k] < target) begin
      errors++;
      $display("FAIL wait_frames dut%0d: frames=%0d required=%0d", k, frames[k], target);
    end
  endtask

  task automatic wait_cap(input int k, input int n, input int budget);
    int t = 0;
    while (!(infr[k] && ncap[k] >= n) && t < budget) begin
      tick(1);
      t++;
    end
    checks++;
    if (!(infr[k] && ncap[k] >= n)) begin
      errors++;
      $display("FAIL wait_cap dut%0d: bytes=%0d required=%0d", k, ncap[k], n);
    end
  endtask

  // use_last=1: wait until the next edge is the final transfer; 0: wait for frame_done
  task automatic wait_flag(input int k, input bit use_last, input int budget);
    int t = 0;
    while (!(use_last ? (cl[k] && rdy[k]) : fd[k]) && t < budget) begin
      tick(1);
      t++;
    end
    checks++;
    if (!(use_last ? (cl[k] && rdy[k]) : fd[k])) begin
      errors++;
      $display("FAIL wait_flag dut%0d: flag %0d not seen", k, use_last);
    end
  endtask

  task automatic check_text(input int k, input int base, input string t, input string name);
    for (int i = 0; i < t.len(); i++) chk(name, cap[k][base + i], t.getc(i));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int t;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; send[k] = 1'b0; rdy[k] = 1'b1; fd_cyc[k] = -1000;
    end
    s0 = '0; s1 = '0; s2 = '0;
    tick(3);
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    tick(2);
    chk("reset_char_out", co[0], 8'h00);
    chk("reset_valid", cv[1], 0);
    chk("reset_busy", bz[2], 0);

    // basic frame
    s0 = 8'b11_10_01_00;
    push(0, {24'b0, s0});
    c0 = cyc;
    pulse_send(0);
    wait_frames(0, 1, 100);
    tick(2);
    chk("first_byte_latency", first_cyc[0] - c0, 2);
    chk("busy_cycles", busy_cnt[0], 29);
    chk("frame_done_delay", fd_cyc[0] - lastx_cyc[0], 1);
    chk("basic_len", ncap[0], 29);
    check_text(0, 0, "0:IDLE 1:ARMD 2:DONE 3:FAIL \n", "basic_text");

    // backpressure 1,0,0,...
    push(0, {24'b0, s0});
    pulse_send(0);
    t = 0;
    while (frames[0] < 2 && t < 300) begin
      rdy[0] = (t % 3 == 0);
      tick(1);
      t++;
    end
    rdy[0] = 1'b1;
    wait_frames(0, 2, 5);
    chk("bp_len", ncap[0], 29);
    check_text(0, 0, "0:IDLE 1:ARMD 2:DONE 3:FAIL \n", "bp_text");

    // two sends while busy collapse into one follow-up frame
    s0 = 8'b00_01_10_11;
    push(0, {24'b0, s0});
    push(0, {24'b0, s0});
    pulse_send(0);
    tick(5);
    pulse_send(0);
    tick(3);
    pulse_send(0);
    wait_frames(0, 4, 200);
    chk("followup_gap", gap[0], 2);
    tick(40);
    chk("collapse_count", frames[0], 4);
    check_text(0, 0, "0:FAIL 1:DONE", "followup_text");

    // send coinciding with the final transfer
    push(0, {24'b0, s0});
    push(0, {24'b0, s0});
    pulse_send(0);
    wait_flag(0, 1'b1, 100);
    pulse_send(0);
    wait_frames(0, 6, 200);
    tick(40);
    chk("last_xfer_send_count", frames[0], 6);

    // send during frame_done
    push(0, {24'b0, s0});
    push(0, {24'b0, s0});
    pulse_send(0);
    wait_flag(0, 1'b0, 100);
    pulse_send(0);
    wait_frames(0, 8, 200);
    tick(40);
    chk("done_send_count", frames[0], 8);

    // reset mid-frame without auto-send: nothing follows
    push(0, {24'b0, s0});
    pulse_send(0);
    wait_cap(0, 10, 100);
    rst[0] = 1'b1;
    tick(1);
    rst[0] = 1'b0;
    chk("midrst_valid", cv[0], 0);
    chk("midrst_busy", bz[0], 0);
    chk("midrst_char_out", co[0], 8'h00);
    tick(40);
    chk("midrst_no_frame", frames[0], 8);

    // auto-send: silent while states stay zero, then one frame on change
    chk("auto_quiet", frames[1], 0);
    s1 = 8'b00_00_01_00;
    push(1, {24'b0, s1});
    wait_frames(1, 1, 100);
    check_text(1, 7, "1:ARMD", "auto_text");
    tick(40);
    chk("auto_single", frames[1], 1);

    // change mid-frame: frozen shadow, then follow-up reporting the change
    s1 = 8'b00_10_01_00;
    push(1, {24'b0, s1});
    wait_cap(1, 5, 100);
    s1 = 8'b11_10_01_00;
    push(1, {24'b0, s1});
    wait_frames(1, 3, 200);
    tick(2);
    chk("auto_gap", gap[1], 2);
    check_text(1, 21, "3:FAIL", "auto_change_text");
    tick(40);
    chk("auto_settle", frames[1], 3);

    // reset mid-frame with auto-send: fresh frame from "0:" afterwards
    push(1, {24'b0, s1});
    pulse_send(1);
    wait_cap(1, 10, 100);
    rst[1] = 1'b1;
    tick(1);
    rst[1] = 1'b0;
    chk("auto_rst_valid", cv[1], 0);
    chk("auto_rst_busy", bz[1], 0);
    @(negedge clk);
    #1;
    push(1, {24'b0, s1});
    wait_frames(1, 4, 100);
    check_text(1, 0, "0:IDLE 1:ARMD", "auto_rst_text");

    // 16 modules, all DONE
    s2 = 32'hAAAA_AAAA;
    push(2, s2);
    pulse_send(2);
    wait_frames(2, 1, 300);
    chk("wide_len", ncap[2], 113);
    chk("wide_first", cap[2][0], 8'h30);
    chk("wide_hex_A", cap[2][70], 8'h41);
    chk("wide_hex_F", cap[2][105], 8'h46);
    chk("wide_newline", cap[2][112], 8'h0A);
    check_text(2, 70, "A:DONE ", "wide_text");
    tick(5);

    for (int k = 0; k < 3; k++) chk("queue_drained", qt[k] - qh[k], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
